// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } arb_state_t;

  localparam int DEF_LOCK_TIMEOUT = 1024;
  localparam int DEF_ACK_TIMEOUT  = 65536;

  // Counter width large enough to reach max(a,b)-1 without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester, searching upward from last_owner+1.
// Latency: purely combinational.
// Backpressure: none; winner is zero when no request is set.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_owner,
  output logic [NREQ-1:0]         winner
);

  // Walk the requesters in rotated order and keep the first one found.
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_owner) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (j == idx) && req[j]) begin
          winner[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte requesters, locking it per message.
// Latency: 1 cycle handshake->uart_we; 1 cycle uart_ack->next req_ready of the owner.
// Backpressure: req_ready is held low until the UART acks the previous byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              uart_we,
  output logic [31:0]       uart_di,
  input  logic              uart_ack,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              ack_err,
  input  logic              err_clr
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_width(LOCK_TIMEOUT, ACK_TIMEOUT);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ACK_MAX  = CW'(ACK_TIMEOUT - 1);

  arb_state_t      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_owner;
  logic [CW-1:0]   cnt;
  logic [7:0]      byte_q;
  logic            last_q;
  logic            we_q;
  logic [NREQ-1:0] grant_q;
  logic            busy_q;
  logic            err_q;

  logic [NREQ-1:0] arb_win;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] owner_oh;
  logic [IW-1:0]   sel_idx;
  logic [7:0]      sel_byte;
  logic            sel_last;
  logic [NREQ-1:0] ready_c;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .req       (req_valid),
    .last_owner(last_owner),
    .winner    (arb_win)
  );

  // One-hot winner to index, and current owner to one-hot.
  always_comb begin
    win_idx  = '0;
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_win[i]) win_idx = IW'(i);
      owner_oh[i] = (owner == IW'(i));
    end
  end

  // Byte/last mux: the arbiter winner in IDLE, the locked owner otherwise.
  always_comb begin
    sel_idx  = (state == ST_IDLE) ? win_idx : owner;
    sel_byte = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_byte = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  // Ready is combinational so a byte transfers in the same cycle it is picked.
  always_comb begin
    ready_c = '0;
    if (!reset) begin
      if (state == ST_IDLE) begin
        ready_c = arb_win;
      end else if ((state == ST_HOLD) && |(req_valid & owner_oh)) begin
        ready_c = owner_oh;
      end
    end
  end

  // Message FSM with registered strobe, grant, busy and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      cnt        <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // A timeout set below is a later assignment and so overrides this clear.
      if (err_clr) err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|ready_c) begin
            owner      <= win_idx;
            last_owner <= win_idx;
            byte_q     <= sel_byte;
            last_q     <= sel_last;
            we_q       <= 1'b1;
            grant_q    <= arb_win;
            busy_q     <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (uart_ack) begin
            cnt <= '0;
            if (last_q) begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              state <= ST_HOLD;
            end
          end else if (cnt == ACK_MAX) begin
            err_q   <= 1'b1;
            cnt     <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (|ready_c) begin
            byte_q <= sel_byte;
            last_q <= sel_last;
            we_q   <= 1'b1;
            cnt    <= '0;
            state  <= ST_SEND;
          end else if (cnt == LOCK_MAX) begin
            cnt     <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt     <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_c;
  assign uart_we   = we_q;
  assign uart_di   = {24'h0, byte_q};
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign ack_err   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: bench acks the UART on demand or withholds acks to force timeouts.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              uart_we;
  logic [31:0]       uart_di;
  logic              uart_ack;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              ack_err;
  logic              err_clr;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .LOCK_TIMEOUT(20),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .uart_we  (uart_we),
    .uart_di  (uart_di),
    .uart_ack (uart_ack),
    .grant    (grant),
    .busy     (busy),
    .ack_err  (ack_err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse;
    uart_ack = 1'b1;
    tick;
    uart_ack = 1'b0;
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
  endtask

  task automatic reset_pulse;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'hF;
    req_data  = '0;
    req_last  = '0;
    uart_ack  = 1'b0;
    err_clr   = 1'b0;
    tick;
    tick;

    // Reset state, with requests pending to prove ready is held off.
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_grant", 32'(grant),     32'h0);
    check("rst_we",    32'(uart_we),   32'h0);
    check("rst_err",   32'(ack_err),   32'h0);
    check("rst_di",    uart_di,        32'h0);
    req_valid = '0;
    reset     = 1'b0;
    #1;

    // Single byte from requester 0.
    set_byte(0, 8'h41);
    req_last  = 4'b0001;
    req_valid = 4'b0001;
    #1;
    check("s1_ready", 32'(req_ready), 32'h1);
    tick;
    req_valid = '0;
    #1;
    check("s1_we",    32'(uart_we),   32'h1);
    check("s1_di",    uart_di,        32'h41);
    check("s1_grant", 32'(grant),     32'h1);
    check("s1_busy",  32'(busy),      32'h1);
    check("s1_rdy0",  32'(req_ready), 32'h0);
    tick;
    check("s1_we_lo", 32'(uart_we),   32'h0);
    check("s1_di_hd", uart_di,        32'h41);
    ack_pulse;
    check("s1_idle",  32'(busy),      32'h0);
    check("s1_gnt0",  32'(grant),     32'h0);

    // Two requesters after reset: 1 first, then 2.
    reset_pulse;
    set_byte(1, 8'h11);
    set_byte(2, 8'h22);
    req_last  = 4'b0110;
    req_valid = 4'b0110;
    #1;
    check("s2_ready1", 32'(req_ready), 32'h2);
    tick;
    req_valid = 4'b0100;
    #1;
    check("s2_grant1", 32'(grant),     32'h2);
    check("s2_di1",    uart_di,        32'h11);
    tick;
    check("s2_wait_rdy", 32'(req_ready), 32'h0);
    ack_pulse;
    check("s2_ready2", 32'(req_ready), 32'h4);
    check("s2_idle",   32'(busy),      32'h0);
    tick;
    req_valid = '0;
    #1;
    check("s2_grant2", 32'(grant),     32'h4);
    check("s2_di2",    uart_di,        32'h22);
    check("s2_we2",    32'(uart_we),   32'h1);
    tick;
    ack_pulse;
    check("s2_done",   32'(busy),      32'h0);

    // Three-byte message from 0 while 3 is waiting: no interleave.
    reset_pulse;
    set_byte(0, 8'h30);
    set_byte(3, 8'h33);
    req_last  = 4'b1000;
    req_valid = 4'b1001;
    #1;
    check("s3_ready0", 32'(req_ready), 32'h1);
    tick;
    set_byte(0, 8'h31);
    #1;
    check("s3_di0",    uart_di,        32'h30);
    tick;
    ack_pulse;
    check("s3_hold_rdy1", 32'(req_ready), 32'h1);
    check("s3_hold_gnt",  32'(grant),     32'h1);
    tick;
    check("s3_di1",    uart_di,        32'h31);
    set_byte(0, 8'h32);
    req_last = 4'b1001;
    tick;
    ack_pulse;
    check("s3_hold_rdy2", 32'(req_ready), 32'h1);
    tick;
    check("s3_di2",    uart_di,        32'h32);
    req_valid = 4'b1000;
    tick;
    ack_pulse;
    check("s3_ready3", 32'(req_ready), 32'h8);
    tick;
    req_valid = '0;
    #1;
    check("s3_di3",    uart_di,        32'h33);
    check("s3_grant3", 32'(grant),     32'h8);
    tick;
    ack_pulse;

    // Owner goes silent mid-message: lock held for LOCK_TIMEOUT cycles.
    set_byte(0, 8'h55);
    set_byte(3, 8'h66);
    req_last  = 4'b1000;
    req_valid = 4'b1001;
    #1;
    check("s4_ready0", 32'(req_ready), 32'h1);
    tick;
    req_valid = 4'b1000;
    tick;
    ack_pulse;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("s4_hold_rdy%0d", i),  32'(req_ready), 32'h0);
      check($sformatf("s4_hold_busy%0d", i), 32'(busy),      32'h1);
      tick;
    end
    check("s4_released", 32'(busy),      32'h0);
    check("s4_ready3",   32'(req_ready), 32'h8);
    tick;
    req_valid = '0;
    #1;
    check("s4_grant3", 32'(grant), 32'h8);
    check("s4_di3",    uart_di,    32'h66);
    tick;
    ack_pulse;

    // Missing ack: error after 16 WAIT cycles, then cleared.
    set_byte(1, 8'h77);
    req_last  = 4'b0010;
    req_valid = 4'b0010;
    #1;
    check("s5_ready1", 32'(req_ready), 32'h2);
    tick;
    req_valid = '0;
    tick;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("s5_wait_err%0d", i),  32'(ack_err), 32'h0);
      check($sformatf("s5_wait_busy%0d", i), 32'(busy),    32'h1);
      tick;
    end
    check("s5_err_set", 32'(ack_err), 32'h1);
    check("s5_idle",    32'(busy),    32'h0);
    ack_pulse;
    check("s5_stray_ack_busy", 32'(busy),    32'h0);
    check("s5_stray_ack_we",   32'(uart_we), 32'h0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    #1;
    check("s5_err_clr", 32'(ack_err), 32'h0);

    // Timeout coinciding with err_clr: set wins.
    set_byte(2, 8'h88);
    req_last  = 4'b0100;
    req_valid = 4'b0100;
    #1;
    check("s6_ready2", 32'(req_ready), 32'h4);
    tick;
    req_valid = '0;
    tick;
    err_clr = 1'b1;
    for (int i = 0; i < 16; i++) tick;
    check("s6_set_wins", 32'(ack_err), 32'h1);
    err_clr = 1'b0;

    // Reset during WAIT: outputs cleared, requester 0 wins next.
    set_byte(1, 8'h99);
    req_last  = 4'b0010;
    req_valid = 4'b0010;
    #1;
    check("s7_ready1", 32'(req_ready), 32'h2);
    tick;
    req_valid = '0;
    tick;
    check("s7_in_wait", 32'(busy), 32'h1);
    reset = 1'b1;
    tick;
    check("s7_rst_we",    32'(uart_we),   32'h0);
    check("s7_rst_busy",  32'(busy),      32'h0);
    check("s7_rst_grant", 32'(grant),     32'h0);
    check("s7_rst_err",   32'(ack_err),   32'h0);
    check("s7_rst_ready", 32'(req_ready), 32'h0);
    check("s7_rst_di",    uart_di,        32'h0);
    reset = 1'b0;
    set_byte(0, 8'hA0);
    set_byte(2, 8'hA2);
    req_last  = 4'b0101;
    req_valid = 4'b0101;
    #1;
    check("s7_ready0", 32'(req_ready), 32'h1);
    tick;
    req_valid = '0;
    #1;
    check("s7_grant0", 32'(grant), 32'h1);
    check("s7_di0",    uart_di,     32'hA0);
    tick;
    ack_pulse;
    check("s7_done", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
